// File: rtl/hazard_control.sv
// rtl/hazard_control.sv - stall/flush control for the 5-stage pipeline with mult/div busy tracking and perf counters
module hazard_control #(
    parameter int MD_LATENCY = 4,
    parameter int STAT_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        idRs,
    input  logic [4:0]        idRt,
    input  logic              idUsesRs,
    input  logic              idUsesRt,
    input  logic              idHiLoUse,
    input  logic [4:0]        exWriteReg,
    input  logic              exRegWrite,
    input  logic              exMemRead,
    input  logic              exMulDivStart,
    input  logic              exRedirect,
    output logic              pcStall,
    output logic              ifidStall,
    output logic              ifidFlush,
    output logic              idexFlush,
    output logic              mdBusy,
    output logic [STAT_W-1:0] stallCount,
    output logic [STAT_W-1:0] redirectCount
);

    localparam logic [3:0]        MD_LOAD  = 4'(MD_LATENCY);
    localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

    logic [3:0]        mdCount_q, mdCount_d;
    logic [STAT_W-1:0] stallCount_q, stallCount_d;
    logic [STAT_W-1:0] redirectCount_q, redirectCount_d;

    logic loadUse;
    logic hiloHaz;
    logic stallReq;

    always_comb begin
        loadUse  = exMemRead && exRegWrite && (exWriteReg != 5'd0) &&
                   ((idUsesRs && (idRs == exWriteReg)) ||
                    (idUsesRt && (idRt == exWriteReg)));
        // busy is forced low in reset so an aborted mult/div window is not visible
        mdBusy   = !reset && (mdCount_q != 4'd0);
        hiloHaz  = idHiLoUse && (mdBusy || exMulDivStart);
        stallReq = loadUse || hiloHaz;
    end

    always_comb begin
        pcStall   = 1'b0;
        ifidStall = 1'b0;
        ifidFlush = 1'b0;
        idexFlush = 1'b0;
        if (reset) begin
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
        end else if (exRedirect) begin
            // ID holds a wrong-path instruction, so any stall it requests is moot
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
        end else if (stallReq) begin
            pcStall   = 1'b1;
            ifidStall = 1'b1;
            idexFlush = 1'b1;
        end
    end

    always_comb begin
        mdCount_d       = mdCount_q;
        stallCount_d    = stallCount_q;
        redirectCount_d = redirectCount_q;
        if (exMulDivStart) begin
            mdCount_d = MD_LOAD;
        end else if (mdCount_q != 4'd0) begin
            mdCount_d = mdCount_q - 4'd1;
        end
        if (pcStall && !(&stallCount_q)) begin
            stallCount_d = stallCount_q + STAT_ONE;
        end
        if (exRedirect && !(&redirectCount_q)) begin
            redirectCount_d = redirectCount_q + STAT_ONE;
        end
    end

    // state moves on the falling edge, in step with the pipeline stage registers
    always_ff @(negedge clk) begin
        if (reset) begin
            mdCount_q       <= 4'd0;
            stallCount_q    <= '0;
            redirectCount_q <= '0;
        end else begin
            mdCount_q       <= mdCount_d;
            stallCount_q    <= stallCount_d;
            redirectCount_q <= redirectCount_d;
        end
    end

    assign stallCount    = stallCount_q;
    assign redirectCount = redirectCount_q;

endmodule

// File: tb/tb_hazard_control.sv
// tb/tb_hazard_control.sv - directed and random checks of hazard_control against a rule-level model
module tb_hazard_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  idRs, idRt, exWriteReg;
    logic        idUsesRs, idUsesRt, idHiLoUse;
    logic        exRegWrite, exMemRead, exMulDivStart, exRedirect;

    logic        pcStall, ifidStall, ifidFlush, idexFlush, mdBusy;
    logic [31:0] stallCount, redirectCount;
    logic        s_pcStall, s_ifidStall, s_ifidFlush, s_idexFlush, s_mdBusy;
    logic [3:0]  s_stallCount, s_redirectCount;

    int vectors = 0;
    int miscompares = 0;

    // reference state: remaining busy cycles and plain integer counters
    int     md_rem;
    longint stall_n, redir_n;
    int     stall4, redir4;
    int     stall_seen;

    logic e_pc, e_ifs, e_iff, e_idf, e_busy;

    always #5 clk = ~clk;

    hazard_control #(.MD_LATENCY(4), .STAT_W(32)) dut (
        .clk(clk), .reset(reset), .idRs(idRs), .idRt(idRt),
        .idUsesRs(idUsesRs), .idUsesRt(idUsesRt), .idHiLoUse(idHiLoUse),
        .exWriteReg(exWriteReg), .exRegWrite(exRegWrite), .exMemRead(exMemRead),
        .exMulDivStart(exMulDivStart), .exRedirect(exRedirect),
        .pcStall(pcStall), .ifidStall(ifidStall), .ifidFlush(ifidFlush),
        .idexFlush(idexFlush), .mdBusy(mdBusy),
        .stallCount(stallCount), .redirectCount(redirectCount)
    );

    hazard_control #(.MD_LATENCY(4), .STAT_W(4)) dut_s (
        .clk(clk), .reset(reset), .idRs(idRs), .idRt(idRt),
        .idUsesRs(idUsesRs), .idUsesRt(idUsesRt), .idHiLoUse(idHiLoUse),
        .exWriteReg(exWriteReg), .exRegWrite(exRegWrite), .exMemRead(exMemRead),
        .exMulDivStart(exMulDivStart), .exRedirect(exRedirect),
        .pcStall(s_pcStall), .ifidStall(s_ifidStall), .ifidFlush(s_ifidFlush),
        .idexFlush(s_idexFlush), .mdBusy(s_mdBusy),
        .stallCount(s_stallCount), .redirectCount(s_redirectCount)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        reset = 1'b0; idRs = 5'd0; idRt = 5'd0; idUsesRs = 1'b0; idUsesRt = 1'b0;
        idHiLoUse = 1'b0; exWriteReg = 5'd0; exRegWrite = 1'b0; exMemRead = 1'b0;
        exMulDivStart = 1'b0; exRedirect = 1'b0;
    endtask

    // one cycle: check outputs mid-cycle, then advance the model across the negedge
    task automatic step();
        logic ld, hilo;
        @(posedge clk); #1;
        ld = exMemRead && exRegWrite && (exWriteReg != 0) &&
             ((idUsesRs && idRs == exWriteReg) || (idUsesRt && idRt == exWriteReg));
        e_busy = !reset && (md_rem > 0);
        hilo = idHiLoUse && (e_busy || exMulDivStart);
        e_pc  = !reset && !exRedirect && (ld || hilo);
        e_ifs = e_pc;
        e_iff = reset || exRedirect;
        e_idf = reset || exRedirect || e_pc;
        chk("pcStall",   pcStall,   e_pc);
        chk("ifidStall", ifidStall, e_ifs);
        chk("ifidFlush", ifidFlush, e_iff);
        chk("idexFlush", idexFlush, e_idf);
        chk("mdBusy",    mdBusy,    e_busy);
        chk("stallCount",    stallCount,    stall_n);
        chk("redirectCount", redirectCount, redir_n);
        chk("stallCount4",    s_stallCount,    stall4);
        chk("redirectCount4", s_redirectCount, redir4);
        chk("s_pcStall", s_pcStall, e_pc);
        if (e_pc) stall_seen++;
        @(negedge clk);
        if (reset) begin
            md_rem = 0; stall_n = 0; redir_n = 0; stall4 = 0; redir4 = 0;
        end else begin
            if (exMulDivStart) md_rem = 4;
            else if (md_rem > 0) md_rem = md_rem - 1;
            if (e_pc) begin
                stall_n = (stall_n < 64'hFFFF_FFFF) ? stall_n + 1 : stall_n;
                stall4  = (stall4 < 15) ? stall4 + 1 : 15;
            end
            if (exRedirect) begin
                redir_n = (redir_n < 64'hFFFF_FFFF) ? redir_n + 1 : redir_n;
                redir4  = (redir4 < 15) ? redir4 + 1 : 15;
            end
        end
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        md_rem = 0; stall_n = 0; redir_n = 0; stall4 = 0; redir4 = 0; stall_seen = 0;
        @(negedge clk); #1;
        step();

        // load-use on rs: one bubble, then clears
        idle();
        exMemRead = 1; exRegWrite = 1; exWriteReg = 5'd8; idUsesRs = 1; idRs = 5'd8;
        step();
        chk("loaduse_count", stallCount, 1);
        idle();
        step();
        // destination r0 never stalls
        exMemRead = 1; exRegWrite = 1; exWriteReg = 5'd0; idUsesRt = 1; idRt = 5'd0;
        step();
        idle();

        // mult/div followed directly by a HI/LO user
        stall_seen = 0;
        exMulDivStart = 1; idHiLoUse = 1;
        step();
        exMulDivStart = 0;
        for (int i = 0; i < 6; i++) step();
        chk("md_stall_len", stall_seen, 5);
        chk("md_idle_after", mdBusy, 0);

        // redirect beats load-use
        idle();
        exRedirect = 1; exMemRead = 1; exRegWrite = 1; exWriteReg = 5'd9; idUsesRt = 1; idRt = 5'd9;
        step();
        idle();

        // non-HI/LO instruction while busy
        exMulDivStart = 1;
        step();
        exMulDivStart = 0; idUsesRs = 1; idRs = 5'd3;
        stall_seen = 0;
        for (int i = 0; i < 5; i++) step();
        chk("nonhilo_nostall", stall_seen, 0);
        idle();

        // reset with mdCount at 2 aborts the busy window
        exMulDivStart = 1;
        step();
        exMulDivStart = 0;
        step();
        step();
        reset = 1;
        step();
        reset = 0; idHiLoUse = 1;
        step();
        chk("post_reset_nostall", pcStall, 0);
        idle();

        // saturation of the narrow counter
        exMemRead = 1; exRegWrite = 1; exWriteReg = 5'd17; idUsesRs = 1; idRs = 5'd17;
        for (int i = 0; i < 20; i++) step();
        chk("sat_stall4", s_stallCount, 15);
        idle();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            reset         = ($urandom_range(0, 39) == 0);
            idRs          = 5'($urandom_range(0, 3));
            idRt          = 5'($urandom_range(0, 3));
            exWriteReg    = 5'($urandom_range(0, 3));
            idUsesRs      = 1'($urandom);
            idUsesRt      = 1'($urandom);
            idHiLoUse     = ($urandom_range(0, 2) == 0);
            exRegWrite    = 1'($urandom);
            exMemRead     = 1'($urandom);
            exMulDivStart = ($urandom_range(0, 9) == 0);
            exRedirect    = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
